// File: rtl/rr_mux_arbiter4.sv
// rr_mux_arbiter4: round-robin arbiter that owns a shared 4:1 datapath mux.
// A grant is held for a whole packet, until the granted requester's last
// beat is accepted; the next search starts just after that requester.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   req[3:0]          requester k has a valid beat on data_k
//   last[3:0]         requester k's current beat ends its packet
//   data0..data3      requester beats (WIDTH bits)
//   in_ready[3:0]     beat of the granted requester accepted (combinational)
//   out_valid         selected beat valid (combinational)
//   out_data          selected beat (combinational)
//   out_last          selected beat ends the packet (combinational)
//   out_ready         sink accepts the beat
//   grant[3:0]        registered one-hot grant, zero when idle
//   sel[1:0]          registered mux select, index of the granted requester
//   busy              registered, high while a packet is granted
module rr_mux_arbiter4 #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [3:0]       req,
   input  logic [3:0]       last,
   input  logic [WIDTH-1:0] data0,
   input  logic [WIDTH-1:0] data1,
   input  logic [WIDTH-1:0] data2,
   input  logic [WIDTH-1:0] data3,
   output logic [3:0]       in_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   output logic             out_last,
   input  logic             out_ready,
   output logic [3:0]       grant,
   output logic [1:0]       sel,
   output logic             busy
);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] BUSY = 1'b1;

   logic [0:0] state, state_nx;
   logic [3:0] grant_nx;
   logic [1:0] sel_nx;
   logic       busy_nx;
   logic [1:0] ptr, ptr_nx;
   logic [1:0] pick;
   logic       found;
   logic       xfer;

   // Round-robin search: walk offsets downward so the smallest offset from ptr wins.
   always_comb begin
      logic [1:0] idx;
      pick  = 2'd0;
      found = 1'b0;
      idx   = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         idx = ptr + 2'(i);
         if (req[idx]) begin
            pick  = idx;
            found = 1'b1;
         end
      end
   end

   // Datapath and handshakes are combinational from the frozen select.
   always_comb begin
      out_valid = (state == BUSY) && req[sel];
      in_ready  = ((state == BUSY) && out_ready) ? grant : 4'b0000;
      out_last  = last[sel];
      case (sel)
         2'd0:    out_data = data0;
         2'd1:    out_data = data1;
         2'd2:    out_data = data2;
         default: out_data = data3;
      endcase
   end

   assign xfer = out_valid && out_ready;

   // Next-state logic.
   always_comb begin
      state_nx = state;
      grant_nx = grant;
      sel_nx   = sel;
      busy_nx  = busy;
      ptr_nx   = ptr;
      case (state)
         IDLE: begin
            if (found) begin
               state_nx = BUSY;
               grant_nx = 4'b0001 << pick;
               sel_nx   = pick;
               busy_nx  = 1'b1;
            end
         end
         default: begin
            if (xfer && out_last) begin
               state_nx = IDLE;
               grant_nx = 4'b0000;
               busy_nx  = 1'b0;
               ptr_nx   = sel + 2'd1;
            end
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         grant <= 4'b0000;
         sel   <= 2'd0;
         busy  <= 1'b0;
         ptr   <= 2'd0;
      end else begin
         state <= state_nx;
         grant <= grant_nx;
         sel   <= sel_nx;
         busy  <= busy_nx;
         ptr   <= ptr_nx;
      end
   end

endmodule

// File: tb/tb_rr_mux_arbiter4.sv
// tb_rr_mux_arbiter4: scoreboard bench for rr_mux_arbiter4. A driver issues
// directed then random stimulus at the falling edge and pushes the reference
// model's expectations; a monitor pops and compares them.
module tb_rr_mux_arbiter4;

   typedef struct packed {
      logic [3:0] grant;
      logic [1:0] sel;
      logic       busy;
      logic       ov;
      logic [3:0] ir;
   } status_t;

   typedef struct packed {
      logic [7:0] data;
      logic       last;
      logic [1:0] src;
   } beat_t;

   logic       clk;
   logic       rst_n;
   logic [3:0] req;
   logic [3:0] last;
   logic [7:0] data0, data1, data2, data3;
   logic [3:0] in_ready;
   logic       out_valid;
   logic [7:0] out_data;
   logic       out_last;
   logic       out_ready;
   logic [3:0] grant;
   logic [1:0] sel;
   logic       busy;

   rr_mux_arbiter4 #(.WIDTH(8)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .last(last),
      .data0(data0), .data1(data1), .data2(data2), .data3(data3),
      .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
      .out_last(out_last), .out_ready(out_ready),
      .grant(grant), .sel(sel), .busy(busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   status_t stat_q[$];
   beat_t   beat_q[$];
   int      checks = 0;
   int      errors = 0;
   bit      done   = 1'b0;

   // Reference model: packet-level view of who owns the channel.
   bit       m_busy = 1'b0;
   int       m_idx  = 0;
   int       m_ptr  = 0;
   int       m_sel  = 0;
   bit       m_xfer;
   int       m_xfer_idx;
   int       rem[4];

   function automatic logic [7:0] dsel(input int k);
      case (k)
         0:       return data0;
         1:       return data1;
         2:       return data2;
         default: return data3;
      endcase
   endfunction

   // Compute this cycle's expectations from current inputs, then advance the model.
   task automatic step();
      status_t s;
      beat_t   b;
      m_xfer = 1'b0;
      if (!rst_n) begin
         m_busy = 1'b0; m_ptr = 0; m_sel = 0; m_idx = 0;
      end
      s.grant = m_busy ? 4'(1 << m_idx) : 4'b0000;
      s.sel   = 2'(m_sel);
      s.busy  = m_busy;
      s.ov    = m_busy && req[m_idx];
      s.ir    = (m_busy && out_ready) ? s.grant : 4'b0000;
      stat_q.push_back(s);
      if (rst_n && s.ov && out_ready) begin
         b.data = dsel(m_idx);
         b.last = last[m_idx];
         b.src  = 2'(m_idx);
         beat_q.push_back(b);
         m_xfer     = 1'b1;
         m_xfer_idx = m_idx;
         if (last[m_idx]) begin
            m_busy = 1'b0;
            m_ptr  = (m_idx + 1) % 4;
         end
      end else if (rst_n && !m_busy && req != 4'b0000) begin
         for (int k = 0; k < 4; k++) begin
            if (!m_busy && req[(m_ptr + k) % 4]) begin
               m_idx  = (m_ptr + k) % 4;
               m_busy = 1'b1;
               m_sel  = m_idx;
            end
         end
      end
   endtask

   task automatic drive(input logic rs, input logic [3:0] rq, input logic [3:0] ls,
                        input logic [7:0] d0, input logic [7:0] d1,
                        input logic [7:0] d2, input logic [7:0] d3, input logic ordy);
      @(negedge clk);
      rst_n = rs; req = rq; last = ls;
      data0 = d0; data1 = d1; data2 = d2; data3 = d3;
      out_ready = ordy;
      step();
   endtask

   // Driver.
   initial begin
      logic [3:0] rq, ls;
      rst_n = 1'b0; req = '0; last = '0; out_ready = 1'b0;
      data0 = '0; data1 = '0; data2 = '0; data3 = '0;
      for (int k = 0; k < 4; k++) rem[k] = 0;

      drive(1'b0, 4'b0000, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
      drive(1'b0, 4'b0000, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
      // Single beat from requester 0.
      repeat (2) drive(1'b1, 4'b0001, 4'b0001, 8'hA5, 8'h00, 8'h00, 8'h00, 1'b1);
      drive(1'b1, 4'b0000, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
      // Everyone requesting single beats: rotation with idle gaps.
      repeat (16) drive(1'b1, 4'b1111, 4'b1111, 8'h10, 8'h20, 8'h30, 8'h40, 1'b1);
      // Stalled sink, then requester drop, then mid-packet reset.
      repeat (6) drive(1'b1, 4'b1111, 4'b0000, 8'h11, 8'h22, 8'h33, 8'h44, 1'b0);
      repeat (3) drive(1'b1, 4'b1110, 4'b0000, 8'h55, 8'h66, 8'h77, 8'h88, 1'b1);
      drive(1'b0, 4'b1100, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
      repeat (3) drive(1'b1, 4'b1100, 4'b0100, 8'h01, 8'h02, 8'h03, 8'h04, 1'b1);

      // Random packets from each requester.
      for (int c = 0; c < 3000; c++) begin
         for (int k = 0; k < 4; k++)
            if (rem[k] == 0 && $urandom_range(1, 0) == 1) rem[k] = $urandom_range(4, 1);
         for (int k = 0; k < 4; k++) begin
            rq[k] = (rem[k] > 0) && ($urandom_range(9, 0) != 0);
            ls[k] = (rem[k] == 1);
         end
         if (c == 1500) begin
            drive(1'b0, rq, ls, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'b1);
            for (int k = 0; k < 4; k++) rem[k] = 0;
         end else begin
            drive(1'b1, rq, ls, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                  $urandom_range(3, 0) != 0);
         end
         if (m_xfer && rem[m_xfer_idx] > 0) rem[m_xfer_idx]--;
      end

      #3;
      done = 1'b1;
      checks++;
      if (beat_q.size() != 0) begin
         errors++;
         $display("FAIL beat_drain: %0d expected beats never seen, required 0", beat_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Monitor.
   initial begin
      status_t e, a;
      beat_t   eb;
      forever begin
         @(negedge clk);
         #2;
         if (!done) begin
            a = '{grant: grant, sel: sel, busy: busy, ov: out_valid, ir: in_ready};
            checks++;
            if (stat_q.size() == 0) begin
               errors++;
               $display("FAIL status_underflow at %0t: no expectation queued", $time);
            end else begin
               e = stat_q.pop_front();
               if (a !== e) begin
                  errors++;
                  $display("FAIL status at %0t: got grant=%b sel=%0d busy=%b ov=%b ir=%b, required grant=%b sel=%0d busy=%b ov=%b ir=%b",
                           $time, a.grant, a.sel, a.busy, a.ov, a.ir,
                           e.grant, e.sel, e.busy, e.ov, e.ir);
               end
            end
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
               checks++;
               if (beat_q.size() == 0) begin
                  errors++;
                  $display("FAIL beat_unexpected at %0t: got data=%h last=%b sel=%0d, required none",
                           $time, out_data, out_last, sel);
               end else begin
                  eb = beat_q.pop_front();
                  if (out_data !== eb.data || out_last !== eb.last || sel !== eb.src) begin
                     errors++;
                     $display("FAIL beat at %0t: got data=%h last=%b sel=%0d, required data=%h last=%b sel=%0d",
                              $time, out_data, out_last, sel, eb.data, eb.last, eb.src);
                  end
               end
            end
         end
      end
   end

endmodule

// File: doc/rr_mux_arbiter4.md
Name: rr_mux_arbiter4

Overview:
- Round-robin scheduler that shares a single 4:1 datapath mux and one output channel among four requesters.
- Each requester sends packets of one or more beats with valid/ready handshakes.
- The arbiter owns the mux select and holds the grant until the granted requester's last beat is accepted.
- Sits in front of any shared sink (bus, serializer, FIFO) fed by the mux.

Parameters:
- WIDTH, 8, data width of each requester input and of out_data.

Ports:
- clk  input  1  sole clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  4  req[k]: requester k has a valid beat on data_k.
- last  input  4  last[k]: current beat of requester k ends its packet; meaningful only when req[k]=1.
- data0  input  WIDTH  requester 0 beat.
- data1  input  WIDTH  requester 1 beat.
- data2  input  WIDTH  requester 2 beat.
- data3  input  WIDTH  requester 3 beat.
- in_ready  output  4  in_ready[k]: beat of requester k accepted this cycle when req[k]=1.
- out_valid  output  1  output beat valid.
- out_data  output  WIDTH  selected beat.
- out_last  output  1  selected beat is the packet end.
- out_ready  input  1  sink accepts the beat.
- grant  output  4  one-hot registered grant; all-zero when idle.
- sel  output  2  registered mux select {s1,s0}, encoding of the granted index.
- busy  output  1  high while a packet is granted.

Behaviour:
- Reset values (async, rst_n=0): state IDLE, grant=0000, sel=00, busy=0, priority pointer ptr=0. Outputs out_valid=0 and in_ready=0000 follow from state.
- State IDLE:
  - If req=0000, stay IDLE.
  - Else, at the next edge, grant the first requester with req set, searching ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - Load grant (one-hot), sel=index and busy=1, then go to BUSY.
  - Arbitration latency: 1 cycle from req asserted in IDLE to grant visible.
- State BUSY:
  - sel and grant are frozen.
  - out_data = mux(data0..data3, sel); out_last = last[sel].
  - out_valid = req[sel]; in_ready = grant when out_ready=1, else 0000.
  - Output paths are combinational from req/last/data/out_ready; no added beat latency.
  - A transfer occurs when out_valid and out_ready are both 1.
  - Transfer with out_last=1: at that edge go to IDLE, grant=0000, busy=0, ptr=(sel+1) mod 4.
  - Transfer with out_last=0: stay BUSY.
  - Granted requester drops req mid-packet: stay BUSY, out_valid=0, grant held indefinitely. No timeout, no preemption.
- Bubble: after each packet end there is one idle cycle before the next grant; max throughput is one packet per (beats+1) cycles.
- Non-granted requests are ignored while BUSY; their in_ready stays 0.
- out_ready=0 stalls: no state change, grant held.
- Simultaneous events: a new req rising in the same cycle as a packet end is seen in the following IDLE cycle under the updated ptr.
- Fairness: a continuously requesting requester is granted within 3 other packets.
- Reset asserted mid-packet: immediately to IDLE/ptr=0. The partial packet is dropped; the sink must tolerate it.
- sel is always consistent with grant: sel=index of the set grant bit; sel holds its last value while idle.

Test Plan:
- Reset, then req=0001 with a single beat (last=0001), data0=8'hA5, out_ready=1 -> grant=0001 and sel=00 one cycle later; same cycle out_valid=1, out_data=A5, in_ready=0001; next cycle grant=0000, ptr=1.
- req=1111, all single-beat, out_ready=1, held for 8 arbitrations from ptr=0 -> grant sequence 0001,0010,0100,1000,0001,0010,0100,1000, idle cycle between each.
- Requester 2 sends a 3-beat packet (data2=11,22,33; last on the third beat) while req=1111 -> sel=10 held for all 3 beats; out_data 11,22,33; no other in_ready bit set; next grant goes to requester 3.
- In BUSY with out_ready=0 for 4 cycles -> out_valid=1, in_ready=0000, grant unchanged; beat transfers on the first cycle out_ready=1.
- Granted requester 1 drops req for 2 cycles mid-packet -> out_valid=0, grant=0010 held; resumes when req returns.
- rst_n pulsed low mid-packet with grant=0100 -> grant=0000, busy=0 immediately (async); after release, req=1100 grants requester 2 (ptr=0 search).
